yadan_spi_slave: RTL and testbench

SPI mode-0 responder for the yadan SoC: the far end of the `spi_master_*` port, used as the on-chip test target and as an SPI peripheral for external hosts. It oversamples SCK, SCS and SDI in the system clock domain, shifts received bytes MSB-first into `rx_data`, and shifts out bytes from a one-deep transmit holding buffer loaded by a valid/ready handshake. It does not generate SCK; all serial activity is driven by the external master.

---
 rtl/yadan_spi_slave.sv | 198 +++++++++++++++++++
 tb/tb_yadan_spi_slave.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/yadan_spi_slave.sv
// yadan_spi_slave: SPI mode-0 responder clocked entirely by the system clock.
// SCK/SCS/SDI are oversampled, received bytes shift in MSB-first, and
// transmit bytes come from a one-deep holding buffer.
//
// Handshake: a byte on tx_data is accepted on any clk edge where
// tx_valid && tx_ready; tx_ready is high exactly when the holding buffer is
// empty. rx_valid/tx_underrun/frame_end are single-cycle pulses with no
// backpressure.
module yadan_spi_slave #(
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       scs,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       frame_end,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Synchronizer stages: [0] and [1] are the two sync flops, [2] is the
    // edge-detect history for sck/scs. sdi is taken from stage [1] so it
    // lines up with the sck edge detected from the same stage.
    logic [2:0] sck_sync_q, scs_sync_q;
    logic [1:0] sdi_sync_q;

    // Counts cycles since reset so the synchronizer reset values are never
    // mistaken for a real high level on scs.
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;

    logic [0:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       sdo_q, sdo_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       frame_end_q, frame_end_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;

    logic       sck_rise, sck_fall, scs_rise, scs_fall, sdi_s;
    logic       load_pt;
    logic [7:0] load_byte;

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign scs_rise = scs_sync_q[1] & ~scs_sync_q[2];
    assign scs_fall = ~scs_sync_q[1] & scs_sync_q[2];
    assign sdi_s    = sdi_sync_q[1];

    // Bring the asynchronous pins into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q <= 3'b000;
            scs_sync_q <= 3'b111;
            sdi_sync_q <= 2'b00;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], sck};
            scs_sync_q <= {scs_sync_q[1:0], scs};
            sdi_sync_q <= {sdi_sync_q[0], sdi};
        end
    end

    // Arm only after a genuine post-reset high on scs has reached the
    // edge-detect stage, so a frame already in progress at reset is ignored.
    always_comb begin
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd3) & scs_sync_q[2]);
    end

    // Frame FSM, shift registers and transmit holding buffer.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        sdo_d         = sdo_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_end_d   = 1'b0;
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        load_pt       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && scs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = 3'd0;
                    load_pt   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (scs_rise) begin
                    // Partial byte and any unsent loaded byte are dropped.
                    state_d     = ST_IDLE;
                    frame_end_d = 1'b1;
                    sdo_d       = 1'b0;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = {rx_shift_q[6:0], sdi_s};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {rx_shift_q[6:0], sdi_s};
                            rx_valid_d = 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        if (bit_cnt_q != 3'd0) begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            sdo_d      = tx_shift_q[6];
                        end else begin
                            load_pt = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        load_byte = buf_full_q ? buf_q : FILL_BYTE;
        if (load_pt) begin
            tx_shift_d = load_byte;
            sdo_d      = load_byte[7];
            if (buf_full_q) begin
                buf_full_d = 1'b0;
            end else begin
                tx_underrun_d = 1'b1;
            end
        end

        // A write can only land while the buffer is empty, so it never
        // collides with a consuming load point.
        if (tx_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_d      = tx_data;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q      <= 2'd0;
            armed_q       <= 1'b0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 8'h00;
            tx_shift_q    <= 8'h00;
            sdo_q         <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_end_q   <= 1'b0;
            buf_q         <= 8'h00;
            buf_full_q    <= 1'b0;
        end else begin
            settle_q      <= settle_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            sdo_q         <= sdo_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_end_q   <= frame_end_d;
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
        end
    end

    // busy is the FSM state itself, doubling as its observation point.
    assign busy        = (state_q == ST_ACTIVE);
    assign sdo_oe      = busy;
    assign sdo         = sdo_q;
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_end   = frame_end_q;

endmodule

// File: tb/tb_yadan_spi_slave.sv
// Testbench for yadan_spi_slave: bit-banged SPI master, behavioural model of
// the transmit buffer and load points, scoreboard for received bytes.
module tb_yadan_spi_slave;

    logic       clk, rst, sck, scs, sdi;
    logic       sdo, sdo_oe, tx_valid, tx_ready, rx_valid, tx_underrun, frame_end, busy;
    logic [7:0] tx_data, rx_data;

    yadan_spi_slave #(.FILL_BYTE(8'hFF)) dut (
        .clk(clk), .rst(rst), .sck(sck), .scs(scs), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .frame_end(frame_end), .busy(busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         n_pushed = 0;
    int         mon_rx = 0, mon_underrun = 0, mon_fend = 0;
    logic [7:0] mon_exp;

    // Reference model: one-deep buffer, fill byte on empty
    logic       m_full = 1'b0;
    logic [7:0] m_buf = 8'h00;
    int         m_underruns = 0;
    int         m_frames = 0;
    logic [7:0] m_bytes[4];
    logic       mid_req[4];
    logic [7:0] mid_val[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_load();
        if (m_full) begin
            m_full = 1'b0;
            return m_buf;
        end
        m_underruns++;
        return 8'hFF;
    endfunction

    task automatic tx_write(input logic [7:0] b);
        check("tx_ready", 32'(tx_ready), 32'(!m_full));
        tx_valid = 1'b1;
        tx_data  = b;
        wait_clk(1);
        tx_valid = 1'b0;
        m_full   = 1'b1;
        m_buf    = b;
    endtask

    // Master: mode 0, 4 clk per sck phase, sdi changes with sck fall.
    task automatic spi_frame(input int nbits, input logic sim_wr, input logic [7:0] sim_byte);
        logic [7:0] cur, miso;
        int idx, b;
        miso = 8'h00;
        sdi  = m_bytes[0][7];
        scs  = 1'b0;
        if (sim_wr) begin
            wait_clk(2);
            check("tx_ready_sim", 32'(tx_ready), 32'(!m_full));
            tx_valid = 1'b1;
            tx_data  = sim_byte;
            wait_clk(1);
            tx_valid = 1'b0;
            cur    = model_load();
            m_full = 1'b1;
            m_buf  = sim_byte;
            wait_clk(3);
        end else begin
            wait_clk(6);
            cur = model_load();
        end
        check("busy_active", 32'(busy), 32'(1));
        check("sdo_oe_active", 32'(sdo_oe), 32'(1));
        for (int i = 0; i < nbits; i++) begin
            idx = i / 8;
            b   = i % 8;
            sdi = m_bytes[idx][7-b];
            if (b == 3 && mid_req[idx] && !m_full) begin
                tx_write(mid_val[idx]);
                wait_clk(3);
            end else begin
                wait_clk(4);
            end
            miso[7-b] = sdo;
            sck = 1'b1;
            if (b == 7) begin
                exp_q.push_back(m_bytes[idx]);
                n_pushed++;
                check($sformatf("miso_byte%0d", idx), 32'(miso), 32'(cur));
            end
            wait_clk(4);
            sck = 1'b0;
            if (b == 7) cur = model_load();
        end
        wait_clk(4);
        scs = 1'b1;
        m_frames++;
        wait_clk(8);
        check("busy_idle", 32'(busy), 32'(0));
        check("sdo_oe_idle", 32'(sdo_oe), 32'(0));
        check("sdo_idle", 32'(sdo), 32'(0));
    endtask

    task automatic clear_mid();
        for (int k = 0; k < 4; k++) begin
            mid_req[k] = 1'b0;
            mid_val[k] = 8'h00;
        end
    endtask

    // Monitor: received bytes against the scoreboard, pulse counters
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                mon_rx++;
                if (exp_q.size() == 0) begin
                    check("rx_valid_spurious", 32'(rx_valid), 32'(0));
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(mon_exp));
                end
            end
            if (tx_underrun) mon_underrun++;
            if (frame_end) mon_fend++;
        end
    end

    initial begin
        int n;
        rst = 1'b1; scs = 1'b1; sck = 1'b0; sdi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        clear_mid();
        wait_clk(3);
        check("rst_sdo", 32'(sdo), 32'(0));
        check("rst_sdo_oe", 32'(sdo_oe), 32'(0));
        check("rst_rx_data", 32'(rx_data), 32'(0));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_underrun", 32'(tx_underrun), 32'(0));
        check("rst_frame_end", 32'(frame_end), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_tx_ready", 32'(tx_ready), 32'(1));
        rst = 1'b0;
        wait_clk(5);

        // Single byte
        tx_write(8'hA5);
        m_bytes[0] = 8'h3C;
        spi_frame(8, 1'b0, 8'h00);
        check("single_tx_ready", 32'(tx_ready), 32'(1));
        check("single_rx_data", 32'(rx_data), 32'(8'h3C));

        // Back-to-back bytes with a mid-frame refill
        tx_write(8'h11);
        m_bytes[0] = 8'hF0; m_bytes[1] = 8'h0F;
        mid_req[0] = 1'b1; mid_val[0] = 8'h22;
        spi_frame(16, 1'b0, 8'h00);
        clear_mid();

        // Underrun
        m_bytes[0] = 8'($urandom);
        spi_frame(8, 1'b0, 8'h00);

        // Abort after 5 bits, then a clean frame
        m_bytes[0] = 8'hC3;
        spi_frame(5, 1'b0, 8'h00);
        m_bytes[0] = 8'h96;
        spi_frame(8, 1'b0, 8'h00);

        // Reset with scs held low: that frame must be ignored
        rst = 1'b1; scs = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        m_full = 1'b0;
        wait_clk(4);
        repeat (8) begin
            sdi = 1'($urandom);
            wait_clk(4);
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
        end
        wait_clk(6);
        check("scs_low_busy", 32'(busy), 32'(0));
        scs = 1'b1;
        wait_clk(8);
        m_bytes[0] = 8'h5A;
        spi_frame(8, 1'b0, 8'h00);
        check("after_rst_rx_data", 32'(rx_data), 32'(8'h5A));

        // Write in the same cycle as the frame-start load point
        m_bytes[0] = 8'($urandom); m_bytes[1] = 8'($urandom);
        spi_frame(16, 1'b1, 8'h77);

        // Randomized frames
        repeat (6) begin
            if (!m_full && ($urandom_range(0, 1) == 1)) tx_write(8'($urandom));
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                m_bytes[k] = 8'($urandom);
                mid_req[k] = 1'($urandom_range(0, 1));
                mid_val[k] = 8'($urandom);
            end
            spi_frame(8 * n, 1'b0, 8'h00);
        end
        clear_mid();

        wait_clk(10);
        check("exp_q_drained", 32'(exp_q.size()), 32'(0));
        check("rx_valid_count", 32'(mon_rx), 32'(n_pushed));
        check("underrun_count", 32'(mon_underrun), 32'(m_underruns));
        check("frame_end_count", 32'(mon_fend), 32'(m_frames));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
